// File: rtl/bus_transfer_arbiter_if.sv
// Handshake and bus-side signals between requesters and the bus transfer arbiter.
// The requester side uses the master modport; the arbiter uses slave.
interface bus_transfer_arbiter_if #(
   parameter int NREQ = 3
);
   logic [NREQ-1:0]   req;
   logic [5*NREQ-1:0] req_src;
   logic [5*NREQ-1:0] req_dst;
   logic [NREQ-1:0]   ack;
   logic [NREQ-1:0]   err;
   logic [4:0]        bus_sel;
   logic [31:0]       dst_we;
   logic              busy;

   modport master (
      output req, req_src, req_dst,
      input  ack, err, bus_sel, dst_we, busy
   );

   modport slave (
      input  req, req_src, req_dst,
      output ack, err, bus_sel, dst_we, busy
   );
endinterface

// File: rtl/bus_transfer_arbiter.sv
// Round-robin owner of the datapath bus: drives the mux select, waits for the bus
// to settle, then strobes one destination write enable and acks the requester.
//
//   state  | meaning
//   IDLE   | no transfer; bus_sel keeps its last value
//   SETTLE | bus_sel driven, settle counter running
//   WRITE  | one cycle: dst_we and ack pulse, next winner chosen
//   REJECT | one cycle: err pulse for an unassigned source code
module bus_transfer_arbiter #(
   parameter int NREQ          = 3,
   parameter int SETTLE_CYCLES = 1,
   parameter int MAX_SRC       = 23
) (
   input  logic                  clock,
   input  logic                  clear_n,
   bus_transfer_arbiter_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SETTLE, WRITE, REJECT} state_t;

   state_t          state_q;
   logic [PW-1:0]   rr_ptr_q;
   logic [PW-1:0]   winner_q;
   logic [CW-1:0]   cnt_q;
   logic [4:0]      dst_q;
   logic [4:0]      bus_sel_q;
   logic [31:0]     dst_we_q;
   logic [NREQ-1:0] ack_q;
   logic [NREQ-1:0] err_q;
   logic            busy_q;

   logic [NREQ-1:0] cand_d;
   logic            win_vld_d;
   logic [PW-1:0]   win_idx_d;
   logic [PW-1:0]   rr_ptr_d;
   logic [4:0]      win_src_d;
   logic [4:0]      win_dst_d;
   logic            src_ok_d;

   always_comb begin : arb
      int idx;
      idx    = 0;
      cand_d = bus.req;
      // the requester being acked/rejected this cycle cannot win again immediately
      if (state_q == WRITE || state_q == REJECT) begin
         cand_d[winner_q] = 1'b0;
      end
      win_vld_d = 1'b0;
      win_idx_d = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!win_vld_d && cand_d[PW'(idx)]) begin
            win_vld_d = 1'b1;
            win_idx_d = PW'(idx);
         end
      end
      win_src_d = '0;
      win_dst_d = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (PW'(j) == win_idx_d) begin
            win_src_d = bus.req_src[5*j +: 5];
            win_dst_d = bus.req_dst[5*j +: 5];
         end
      end
      rr_ptr_d = (int'(win_idx_d) == NREQ - 1) ? '0 : win_idx_d + PW'(1);
      src_ok_d = ({27'b0, win_src_d} <= 32'(MAX_SRC));
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         winner_q  <= '0;
         cnt_q     <= '0;
         dst_q     <= '0;
         bus_sel_q <= '0;
         dst_we_q  <= '0;
         ack_q     <= '0;
         err_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         dst_we_q <= '0;
         ack_q    <= '0;
         err_q    <= '0;
         case (state_q)
            SETTLE: begin
               if (cnt_q == CW'(1)) begin
                  state_q  <= WRITE;
                  dst_we_q <= 32'b1 << dst_q;
                  ack_q    <= NREQ'(1) << winner_q;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            IDLE, WRITE, REJECT: begin
               if (win_vld_d) begin
                  rr_ptr_q <= rr_ptr_d;
                  winner_q <= win_idx_d;
                  dst_q    <= win_dst_d;
                  if (src_ok_d) begin
                     state_q   <= SETTLE;
                     bus_sel_q <= win_src_d;
                     cnt_q     <= CW'(SETTLE_CYCLES);
                     busy_q    <= 1'b1;
                  end else begin
                     state_q <= REJECT;
                     err_q   <= NREQ'(1) << win_idx_d;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.ack     = ack_q;
   assign bus.err     = err_q;
   assign bus.bus_sel = bus_sel_q;
   assign bus.dst_we  = dst_we_q;
   assign bus.busy    = busy_q;
endmodule

// File: doc/bus_transfer_arbiter.md
Name: bus_transfer_arbiter

Overview:
- Shares the 32-bit datapath bus between up to NREQ requesters, for example the control-unit step logic, the I/O port engine and the debug port.
- Each request names one bus source code (5-bit bus multiplexer select) and one destination register code.
- The block arbitrates round-robin, drives the registered mux select, waits a settle interval, then pulses exactly one destination write enable and acknowledges the requester.
- It sits between the requesters and the bus multiplexer / register-file Rin strobes.

Parameters:
- NREQ, 3, number of requesters (2..8).
- SETTLE_CYCLES, 1, cycles bus_sel is held before the write strobe (>=1).
- MAX_SRC, 23, highest legal source code. Codes above it are unassigned mux inputs and are rejected.

Ports:
- clock  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- req  in  NREQ  request i held high until ack[i] or err[i].
- req_src  in  5*NREQ  source code of requester i at bits [5i+4:5i].
- req_dst  in  5*NREQ  destination code of requester i at bits [5i+4:5i].
- ack  out  NREQ  one-cycle grant-complete pulse, one-hot.
- err  out  NREQ  one-cycle reject pulse, one-hot.
- bus_sel  out  5  bus multiplexer select.
- dst_we  out  32  one-hot destination write enable (decoded dst code).
- busy  out  1  high in SETTLE or WRITE.

Behaviour:
- Reset (clear_n low, asynchronous):
  - state=IDLE, rr_ptr=0.
  - bus_sel=0, dst_we=0, ack=0, err=0, busy=0.
  - Applies immediately at any point. An in-flight transfer is abandoned with no ack and no dst_we.
- States: IDLE, SETTLE, WRITE, REJECT.
- Arbitration:
  - Evaluated in IDLE, in the last cycle of WRITE and in REJECT.
  - Candidates are req masked by the requester currently being acked/rejected that cycle.
  - Winner is the first set candidate at or after rr_ptr, wrapping modulo NREQ.
  - On a win: rr_ptr <= winner+1, wrapping NREQ-1 -> 0.
  - The winner's req_src and req_dst are latched at the grant edge. Later changes to them are ignored.
- Grant with legal source (src <= MAX_SRC):
  - Next state SETTLE. bus_sel <= src at that edge. Settle counter loaded with SETTLE_CYCLES.
- Grant with illegal source (src > MAX_SRC):
  - Next state REJECT. bus_sel unchanged, no dst_we.
- SETTLE: bus_sel held, counter decrements each cycle. When the counter reaches 1, next state is WRITE.
- WRITE (exactly 1 cycle):
  - dst_we[dst]=1, all other bits 0. ack[winner]=1. bus_sel still held.
  - Next state SETTLE if any candidate remains (new grant), else IDLE.
- REJECT (1 cycle): err[winner]=1. Next state follows the WRITE rule.
- IDLE: bus_sel keeps its last value, dst_we=0.
- Latency with SETTLE_CYCLES=S: req sampled high in IDLE at cycle t -> bus_sel valid from t+1 -> dst_we/ack in cycle t+1+S.
- Back-to-back throughput: one transfer per S+1 cycles.
- Protocol rules:
  - A requester drops req in the cycle after seeing ack/err, or re-requests by keeping req high with new fields.
  - If req drops before ack, the transfer still completes with the latched fields.
- Outputs are registered: ack, err, dst_we and bus_sel all come from flops. There are no combinational paths from req.
- Invariant: at most one ack/err bit and at most one dst_we bit high in any cycle.

Test Plan:
- Single transfer, S=1: req[0] with src=20 (PC), dst=4 raised in IDLE at cycle 0 -> bus_sel=20 from cycle 1; cycle 2 dst_we=0x00000010 and ack=001; then IDLE, busy=0.
- Round-robin, all three req high from cycle 0, rr_ptr=0 -> acks in order 001, 010, 100 at cycles 2, 4, 6. A second round with only req[2] and req[0] high yields 001 then 100.
- Illegal source: req[1] with src=25 -> cycle 1 state REJECT, err=010 for one cycle, dst_we stays 0, bus_sel unchanged; next pending requester is granted in the following cycle.
- Reset mid-operation: clear_n pulsed low during SETTLE -> all outputs 0 immediately (asynchronous). After release with req[1] still high -> fresh grant, ack arrives 2 cycles later.
- S=3 instance: req[2] with src=17 (LO), dst=16 -> bus_sel=17 held cycles 1-3, dst_we bit 16 and ack=100 at cycle 4.
- Field change after grant: req_src changed from 5 to 9 in cycle 1 -> bus_sel stays 5 through the WRITE cycle.
